// File: rtl/vga_sync_monitor.sv
// Receiver-side VGA timing checker: measures line/frame timing, flags
// sync and blanking faults, and reports lock after consecutive clean frames.
module vga_sync_monitor #(
    parameter int H_TOTAL_CLKS  = 1600,
    parameter int H_PULSE_CLKS  = 192,
    parameter int V_TOTAL_LINES = 525,
    parameter int V_PULSE_LINES = 2,
    parameter bit SYNC_POL      = 1'b0,
    parameter int LOCK_FRAMES   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [1:0]  red_in,
    input  logic [1:0]  green_in,
    input  logic [1:0]  blue_in,
    output logic [11:0] h_period,
    output logic [11:0] h_pulse,
    output logic [10:0] v_lines,
    output logic [10:0] v_pulse,
    output logic        locked,
    output logic        h_err,
    output logic        v_err,
    output logic        blank_err,
    output logic        frame_done,
    output logic [7:0]  err_count
);

    localparam logic [11:0] LP_H_TOTAL = 12'(H_TOTAL_CLKS);
    localparam logic [11:0] LP_H_PULSE = 12'(H_PULSE_CLKS);
    localparam logic [10:0] LP_V_TOTAL = 11'(V_TOTAL_LINES);
    localparam logic [10:0] LP_V_PULSE = 11'(V_PULSE_LINES);
    localparam logic [7:0]  LP_LOCK    = 8'(LOCK_FRAMES);
    localparam logic [11:0] LP_H_MAX   = 12'hFFF;
    localparam logic [10:0] LP_V_MAX   = 11'h7FF;

    typedef enum logic [1:0] {
        SEARCH,
        ACQUIRE,
        LOCKED
    } state_t;

    logic        r_hs_s1;
    logic        r_hs_s2;
    logic        r_vs_s1;
    logic        r_vs_s2;
    logic [5:0]  r_rgb_s1;
    logic [5:0]  r_rgb_s2;

    logic [11:0] r_hcnt;
    logic [11:0] r_pcnt;
    logic [10:0] r_lcnt;
    logic [10:0] r_vpcnt;
    logic        r_h_seen;
    logic        r_v_seen;

    state_t      r_state;
    logic [7:0]  r_good_cnt;
    logic        r_frame_bad;

    logic        w_act_h_s1;
    logic        w_act_h_s2;
    logic        w_act_v_s1;
    logic        w_act_v_s2;
    logic        w_h_rise;
    logic        w_h_fall;
    logic        w_v_rise;
    logic        w_v_fall;
    logic        w_hcnt_sat;
    logic        w_h_err;
    logic        w_v_err;
    logic        w_blank;
    logic        w_any_err;
    logic        w_frame_good;
    logic [7:0]  w_good_inc;

    assign w_act_h_s1 = (r_hs_s1 == SYNC_POL);
    assign w_act_h_s2 = (r_hs_s2 == SYNC_POL);
    assign w_act_v_s1 = (r_vs_s1 == SYNC_POL);
    assign w_act_v_s2 = (r_vs_s2 == SYNC_POL);

    assign w_h_rise = w_act_h_s1 & ~w_act_h_s2;
    assign w_h_fall = ~w_act_h_s1 & w_act_h_s2;
    assign w_v_rise = w_act_v_s1 & ~w_act_v_s2;
    assign w_v_fall = ~w_act_v_s1 & w_act_v_s2;

    // One pulse on the cycle the line counter hits its ceiling.
    assign w_hcnt_sat = ~w_h_rise & (r_hcnt == LP_H_MAX - 12'd1);

    assign w_h_err = (w_h_rise & r_h_seen & (r_hcnt != LP_H_TOTAL))
                   | (w_h_fall & (r_pcnt != LP_H_PULSE))
                   | w_hcnt_sat;

    assign w_v_err = (w_v_rise & r_v_seen & (r_lcnt != LP_V_TOTAL))
                   | (w_v_fall & (r_vpcnt != LP_V_PULSE));

    assign w_blank   = (w_act_h_s2 | w_act_v_s2) & (|r_rgb_s2);
    assign w_any_err = w_h_err | w_v_err | w_blank;

    assign w_frame_good = ~r_frame_bad & ~w_any_err;
    assign w_good_inc   = r_good_cnt + 8'd1;

    // Pipeline resets to the idle sync level so release makes no false edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hs_s1  <= ~SYNC_POL;
            r_hs_s2  <= ~SYNC_POL;
            r_vs_s1  <= ~SYNC_POL;
            r_vs_s2  <= ~SYNC_POL;
            r_rgb_s1 <= 6'd0;
            r_rgb_s2 <= 6'd0;
        end else begin
            r_hs_s1  <= hsync;
            r_hs_s2  <= r_hs_s1;
            r_vs_s1  <= vsync;
            r_vs_s2  <= r_vs_s1;
            r_rgb_s1 <= {red_in, green_in, blue_in};
            r_rgb_s2 <= r_rgb_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hcnt   <= 12'd0;
            r_pcnt   <= 12'd0;
            r_h_seen <= 1'b0;
            h_period <= 12'd0;
            h_pulse  <= 12'd0;
            h_err    <= 1'b0;
        end else begin
            if (w_h_rise) begin
                h_period <= r_hcnt;
                r_hcnt   <= 12'd1;
                r_h_seen <= 1'b1;
            end else if (r_hcnt != LP_H_MAX) begin
                r_hcnt <= r_hcnt + 12'd1;
            end
            if (w_h_fall) begin
                h_pulse <= r_pcnt;
                r_pcnt  <= 12'd0;
            end else if (w_act_h_s1 && r_pcnt != LP_H_MAX) begin
                r_pcnt <= r_pcnt + 12'd1;
            end
            h_err <= w_h_err;
        end
    end

    // A line starting in the same cycle as vsync belongs to the new frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lcnt     <= 11'd0;
            r_vpcnt    <= 11'd0;
            r_v_seen   <= 1'b0;
            v_lines    <= 11'd0;
            v_pulse    <= 11'd0;
            v_err      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (w_v_rise) begin
                v_lines  <= r_lcnt;
                r_lcnt   <= {10'd0, w_h_rise};
                r_v_seen <= 1'b1;
            end else if (w_h_rise && r_lcnt != LP_V_MAX) begin
                r_lcnt <= r_lcnt + 11'd1;
            end
            if (w_v_fall) begin
                v_pulse <= r_vpcnt;
                r_vpcnt <= 11'd0;
            end else if (w_h_rise && w_act_v_s1 && r_vpcnt != LP_V_MAX) begin
                r_vpcnt <= r_vpcnt + 11'd1;
            end
            v_err      <= w_v_err;
            frame_done <= w_v_rise;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blank_err <= 1'b0;
            err_count <= 8'd0;
        end else begin
            blank_err <= w_blank;
            if (w_any_err && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= SEARCH;
            r_good_cnt  <= 8'd0;
            r_frame_bad <= 1'b0;
            locked      <= 1'b0;
        end else begin
            if (w_v_rise) begin
                r_frame_bad <= 1'b0;
            end else if (w_any_err) begin
                r_frame_bad <= 1'b1;
            end
            unique case (r_state)
                SEARCH: begin
                    if (w_v_rise) begin
                        r_state    <= ACQUIRE;
                        r_good_cnt <= 8'd0;
                    end
                end
                ACQUIRE: begin
                    if (w_v_rise) begin
                        if (!w_frame_good) begin
                            r_good_cnt <= 8'd0;
                        end else if (w_good_inc >= LP_LOCK) begin
                            r_good_cnt <= w_good_inc;
                            r_state    <= LOCKED;
                            locked     <= 1'b1;
                        end else begin
                            r_good_cnt <= w_good_inc;
                        end
                    end
                end
                LOCKED: begin
                    // Blanking faults are reported but never break lock.
                    if (w_h_err || w_v_err) begin
                        r_state    <= ACQUIRE;
                        r_good_cnt <= 8'd0;
                        locked     <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= SEARCH;
                    r_good_cnt <= 8'd0;
                    locked     <= 1'b0;
                end
            endcase
        end
    end

endmodule
